// File: rtl/mulu256_pkg.sv
// Types and constants shared by the wide unsigned arithmetic blocks (mulu256, divu256).
package mulu256_pkg;

  localparam int unsigned DEFAULT_N = 256;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    DONE = 3'd3
  } state_t;

endpackage

// File: rtl/mulu256.sv
// Sequential radix-2 shift-add unsigned multiplier: one product bit per CALC cycle,
// zero operands short-circuit straight from LOAD to DONE.
module mulu256
  import mulu256_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] mcnd,
  input  logic [N-1:0] mplr,
  output logic [N-1:0] prod_hi,
  output logic [N-1:0] prod_lo,
  output logic         zro,
  output logic [2:0]   state,
  output logic         data_rdy
);

  localparam int unsigned CW = $clog2(N + 1);

  state_t cur, nxt;

  logic [N-1:0]   mcnd_q, mplr_q;
  logic [2*N:0]   acc;
  logic [2*N-1:0] acc_step;
  logic [N:0]     sum;
  logic [CW-1:0]  cnt;
  logic           zero_op, last_step;

  assign zero_op   = (mcnd_q == '0) || (mplr_q == '0);
  assign last_step = (cnt == CW'(1));
  assign state     = cur;
  assign data_rdy  = (cur == DONE);

  // Upper half is N+1 bits so the add cannot lose its carry; the step's shifted-out
  // top bit is always zero and is re-inserted when the accumulator is written.
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    sum      = acc[2*N:N] + (acc[0] ? {1'b0, mcnd_q} : {(N+1){1'b0}});
    acc_step = {sum, acc[N-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    nxt = zero_op ? DONE : CALC;
      CALC:    if (last_step) nxt = DONE;
      DONE:    if (start) nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnd_q  <= '0;
      mplr_q  <= '0;
      acc     <= '0;
      cnt     <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      zro     <= 1'b0;
    end else begin
      case (cur)
        IDLE, DONE: begin
          if (start) begin
            mcnd_q  <= mcnd;
            mplr_q  <= mplr;
            acc     <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
          end
        end
        LOAD: begin
          if (zero_op) begin
            zro     <= 1'b1;
            prod_hi <= '0;
            prod_lo <= '0;
          end else begin
            zro <= 1'b0;
            cnt <= CW'(N);
            acc <= {{(N+1){1'b0}}, mplr_q};
          end
        end
        CALC: begin
          acc <= {1'b0, acc_step};
          cnt <= cnt - CW'(1);
          // Outputs change only on the final step, so partial products never appear.
          if (last_step) {prod_hi, prod_lo} <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mulu256.md
MULU256 -- requirements
Module: mulu256

Interface
REQ-001 The block SHALL have parameter N, default 256, meaning operand width in bits.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset (low = reset/idle, high = run).
REQ-004 The block SHALL have port start  input  1  request to multiply; sampled on rising clk.
REQ-005 The block SHALL have port mcnd  input  N  unsigned multiplicand; captured when start is accepted.
REQ-006 The block SHALL have port mplr  input  N  unsigned multiplier; captured when start is accepted.
REQ-007 The block SHALL have port prod_hi  output  N  upper N bits of the 2N-bit product.
REQ-008 The block SHALL have port prod_lo  output  N  lower N bits of the 2N-bit product.
REQ-009 The block SHALL have port zro  output  1  high when the accepted operation had a zero operand.
REQ-010 The block SHALL have port state  output  3  current FSM state encoding.
REQ-011 The block SHALL have port data_rdy  output  1  product valid; high only in DONE.

Function
REQ-012 The FSM SHALL use states IDLE=0, LOAD=1, CALC=2, DONE=3; codes 4-7 SHALL return to IDLE on the next edge.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL capture mcnd/mplr, clear the accumulator and go to LOAD.
REQ-014 start SHALL be ignored in LOAD and CALC; captured operands SHALL NOT change while busy.
REQ-015 In LOAD, a zero mcnd or mplr SHALL set zro=1 and a zero product, then go directly to DONE.
REQ-016 In LOAD with both operands nonzero, the block SHALL clear zro, load the iteration counter with N, and go to CALC.
REQ-017 Each CALC cycle SHALL do one radix-2 shift-add step: if the multiplier LSB is 1, add mcnd to the upper half of a 2N+1-bit accumulator; then shift the accumulator right by one.
REQ-018 After exactly N CALC cycles (counter reaches 0), the FSM SHALL enter DONE.
REQ-019 Latency SHALL be N+2 edges from the accepting edge to data_rdy=1, and 2 edges for a zero operand.
REQ-020 In DONE, data_rdy SHALL be 1 and prod_hi/prod_lo/zro SHALL hold until the next accepted start.
REQ-021 A start in DONE SHALL drop data_rdy at that edge and begin a new operation with no idle cycle.
REQ-022 The product SHALL be exact modulo 2^(2N); no overflow is possible, and no sign handling exists.
REQ-023 The counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-024 When rst is low, the block SHALL immediately force state=IDLE, prod_hi=0, prod_lo=0, zro=0, data_rdy=0, and clear the accumulator and counter, independent of clk.
REQ-025 Reset asserted mid-CALC SHALL abort the operation, and no partial product SHALL be visible.
REQ-026 After rst deasserts, the block SHALL stay in IDLE until start=1 is sampled.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/LOAD/CALC/DONE, 3-bit) and the default width constant 256, shared with divu256.
REQ-028 The block SHALL be a single module with no sub-modules; the N+1-bit adder SHALL be inline.

Verification
REQ-029 mcnd='1, mplr='1, start pulse -> after N+2 edges data_rdy=1, prod_hi=ff..fe, prod_lo=00..01, zro=0.
REQ-030 mcnd=12, mplr=5 -> prod_hi=0, prod_lo=60 (0x3c); data_rdy rises exactly N+2 edges after start.
REQ-031 mcnd=100, mplr=0 -> data_rdy after 2 edges, product 0, zro=1, state passes 0->1->3.
REQ-032 mcnd=45, mplr=9 with start held high and operands changed to 7/7 during CALC -> product 405; a second op 49 starts only after DONE.
REQ-033 rst low for 15 ns mid-CALC -> outputs 0 and state=0 asynchronously; a following 5*7 operation gives 35.
REQ-034 Back-to-back: start pulse in DONE with 3*4 -> data_rdy drops at that edge and the result 12 appears N+2 edges later.
